// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host command path: sequencer states,
// keyboard protocol bytes, completion codes and the latched command record.
package ps2_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_CMD,
    S_WAIT_TX,
    S_WAIT_RSP,
    S_SEND_ARG,
    S_WAIT_BAT,
    S_FINISH
  } state_t;

  // Which byte of the command is currently on the wire (and is resent on FE).
  typedef enum logic {
    PH_CMD,
    PH_ARG
  } phase_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_RETRY   = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_DEVICE  = 2'd3
  } err_code_t;

  // Device replies.
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERROR  = 8'hFC;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;

  // Host commands and scan-code prefixes.
  localparam logic [7:0] PS2_RESET     = 8'hFF;
  localparam logic [7:0] PS2_SET_LEDS  = 8'hED;
  localparam logic [7:0] PS2_TYPEMATIC = 8'hF3;
  localparam logic [7:0] PS2_BREAK     = 8'hF0;
  localparam logic [7:0] PS2_EXT0      = 8'hE0;
  localparam logic [7:0] PS2_EXT1      = 8'hE1;

  typedef struct packed {
    logic [7:0] opcode;
    logic       has_arg;
    logic [7:0] arg;
  } cmd_t;

  // Bytes that terminate a response wait after a byte has been sent.
  function automatic logic is_cmd_response(input logic [7:0] b);
    return (b == PS2_ACK) || (b == PS2_RESEND) || (b == PS2_ERROR);
  endfunction

endpackage

// File: rtl/ps2_rsp_timer.sv
// Loadable down-counter used for the response and BAT waits. expire pulses
// in the cycle the count steps from 1 to 0, so a load of N expires N cycles later.
module ps2_rsp_timer #(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] count;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (clear) begin
      count <= '0;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // A load or clear in the same cycle supersedes the pending expiry.
  assign expire = !load && !clear && (count == W'(1));

endmodule

// File: rtl/ps2_cmd_seq.sv
// PS/2 host-to-device command sequencer: sends a one- or two-byte command,
// handles ACK/RESEND/ERROR and the post-reset BAT, forwards all other bytes.
module ps2_cmd_seq
  import ps2_pkg::*;
#(
  parameter int MAX_RETRY   = 3,
  parameter int RSP_TIMEOUT = 500000,
  parameter int BAT_TIMEOUT = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_has_arg,
  input  logic [7:0] cmd_arg,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic       busy,
  output logic       oreq,
  output logic [7:0] obyte,
  input  logic       oack,
  input  logic       tx_timeout,
  input  logic       istrobe,
  input  logic [7:0] ibyte,
  output logic       key_strobe,
  output logic [7:0] key_byte
);

  localparam int TW = $clog2(BAT_TIMEOUT + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TW-1:0] RSP_LOAD  = TW'(RSP_TIMEOUT);
  localparam logic [TW-1:0] BAT_LOAD  = TW'(BAT_TIMEOUT);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  state_t          state,   state_d;
  phase_t          phase,   phase_d;
  cmd_t            cmd_q,   cmd_d;
  logic [RW-1:0]   retry,   retry_d;
  err_code_t       code_q,  code_d;
  logic            err_q,   err_d;
  logic [7:0]      obyte_q, obyte_d;
  logic            key_strobe_q;
  logic [7:0]      key_byte_q;

  logic            tmr_load;
  logic            tmr_clear;
  logic [TW-1:0]   tmr_val;
  logic            tmr_expire;
  logic            consumed;

  ps2_rsp_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .clear    (tmr_clear),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave a value held and infer a latch.
  always_comb begin
    state_d   = state;
    phase_d   = phase;
    cmd_d     = cmd_q;
    retry_d   = retry;
    code_d    = code_q;
    err_d     = err_q;
    obyte_d   = obyte_q;
    tmr_load  = 1'b0;
    tmr_clear = 1'b0;
    tmr_val   = RSP_LOAD;
    consumed  = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          cmd_d   = '{opcode: cmd_byte, has_arg: cmd_has_arg, arg: cmd_arg};
          phase_d = PH_CMD;
          retry_d = '0;
          code_d  = ERR_NONE;
          err_d   = 1'b0;
          obyte_d = cmd_byte;
          state_d = S_SEND_CMD;
        end
      end

      S_SEND_CMD, S_SEND_ARG: state_d = S_WAIT_TX;

      S_WAIT_TX: begin
        if (oack) begin
          tmr_load = 1'b1;
          tmr_val  = RSP_LOAD;
          state_d  = S_WAIT_RSP;
        end else if (tx_timeout) begin
          code_d  = ERR_TIMEOUT;
          state_d = S_FINISH;
        end
      end

      S_WAIT_RSP: begin
        // A response byte beats a coincident expiry; a non-response byte
        // is forwarded and does not hold the expiry off.
        if (istrobe && is_cmd_response(ibyte)) begin
          consumed  = 1'b1;
          tmr_clear = 1'b1;
          if (ibyte == PS2_ACK) begin
            if (phase == PH_CMD && cmd_q.has_arg) begin
              phase_d = PH_ARG;
              retry_d = '0;
              obyte_d = cmd_q.arg;
              state_d = S_SEND_ARG;
            end else if (cmd_q.opcode == PS2_RESET) begin
              tmr_load = 1'b1;
              tmr_val  = BAT_LOAD;
              state_d  = S_WAIT_BAT;
            end else begin
              state_d = S_FINISH;
            end
          end else if (ibyte == PS2_RESEND) begin
            if (retry == RETRY_MAX) begin
              code_d  = ERR_RETRY;
              state_d = S_FINISH;
            end else begin
              retry_d = retry + 1'b1;
              state_d = (phase == PH_CMD) ? S_SEND_CMD : S_SEND_ARG;
            end
          end else begin
            code_d  = ERR_DEVICE;
            state_d = S_FINISH;
          end
        end else if (tmr_expire) begin
          code_d  = ERR_TIMEOUT;
          state_d = S_FINISH;
        end
      end

      S_WAIT_BAT: begin
        if (istrobe && (ibyte == PS2_BAT_OK || ibyte == PS2_ERROR)) begin
          consumed  = 1'b1;
          tmr_clear = 1'b1;
          if (ibyte == PS2_ERROR) code_d = ERR_DEVICE;
          state_d = S_FINISH;
        end else if (tmr_expire) begin
          code_d  = ERR_TIMEOUT;
          state_d = S_FINISH;
        end
      end

      S_FINISH: begin
        err_d   = (code_q != ERR_NONE);
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      phase   <= PH_CMD;
      cmd_q   <= '0;
      retry   <= '0;
      code_q  <= ERR_NONE;
      err_q   <= 1'b0;
      obyte_q <= '0;
    end else begin
      state   <= state_d;
      phase   <= phase_d;
      cmd_q   <= cmd_d;
      retry   <= retry_d;
      code_q  <= code_d;
      err_q   <= err_d;
      obyte_q <= obyte_d;
    end
  end

  // Everything received that was not taken as a command reply goes to the
  // scan-code path one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_strobe_q <= 1'b0;
      key_byte_q   <= '0;
    end else begin
      key_strobe_q <= istrobe && !consumed;
      if (istrobe && !consumed) key_byte_q <= ibyte;
    end
  end

  assign cmd_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE) && (state != S_FINISH);
  assign done       = (state == S_FINISH);
  assign oreq       = (state == S_SEND_CMD) || (state == S_SEND_ARG);
  assign obyte      = obyte_q;
  assign err        = err_q;
  assign err_code   = code_q;
  assign key_strobe = key_strobe_q;
  assign key_byte   = key_byte_q;

endmodule

// File: tb/tb_ps2_cmd_seq.sv
// Bench for ps2_cmd_seq: scripted keyboard/transceiver model, a reply-driven
// outcome model per command, and one compare process watching every cycle.
module tb_ps2_cmd_seq;

  localparam int MAX_RETRY = 3;
  localparam int RSP_TO    = 100;
  localparam int BAT_TO    = 300;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_byte = '0;
  logic       cmd_has_arg = 1'b0;
  logic [7:0] cmd_arg = '0;
  logic       done;
  logic       err;
  logic [1:0] err_code;
  logic       busy;
  logic       oreq;
  logic [7:0] obyte;
  logic       oack = 1'b0;
  logic       tx_timeout = 1'b0;
  logic       istrobe = 1'b0;
  logic [7:0] ibyte = '0;
  logic       key_strobe;
  logic [7:0] key_byte;

  ps2_cmd_seq #(
    .MAX_RETRY   (MAX_RETRY),
    .RSP_TIMEOUT (RSP_TO),
    .BAT_TIMEOUT (BAT_TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_byte    (cmd_byte),
    .cmd_has_arg (cmd_has_arg),
    .cmd_arg     (cmd_arg),
    .done        (done),
    .err         (err),
    .err_code    (err_code),
    .busy        (busy),
    .oreq        (oreq),
    .obyte       (obyte),
    .oack        (oack),
    .tx_timeout  (tx_timeout),
    .istrobe     (istrobe),
    .ibyte       (ibyte),
    .key_strobe  (key_strobe),
    .key_byte    (key_byte)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expectations produced by the model, consumed by the compare process.
  logic [7:0] exp_tx[$];
  logic [7:0] exp_fwd[$];
  int         exp_code[$];

  // Device script: bit 8 set = wait for the next completed transmission first.
  logic [8:0] resp_q[$];
  bit         tx_fail = 1'b0;
  int         t_ack = 0;

  // Transceiver + keyboard model.
  int         tx_cnt = 0;
  int         gap = 0;
  bit         ack_seen = 1'b0;
  logic [8:0] ent;

  always @(negedge clk) begin
    oack       = 1'b0;
    tx_timeout = 1'b0;
    istrobe    = 1'b0;
    if (!rst_n) begin
      tx_cnt   = 0;
      gap      = 0;
      ack_seen = 1'b0;
    end else begin
      if (oreq) begin
        tx_cnt   = 3;
        ack_seen = 1'b0;
      end else if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) begin
          if (tx_fail) tx_timeout = 1'b1;
          else begin
            oack     = 1'b1;
            ack_seen = 1'b1;
            gap      = 2;
            t_ack    = cyc;
          end
        end
      end
      if (resp_q.size() > 0 && (!resp_q[0][8] || ack_seen)) begin
        if (gap > 0) gap--;
        else begin
          ent = resp_q.pop_front();
          if (ent[8]) ack_seen = 1'b0;
          istrobe = 1'b1;
          ibyte   = ent[7:0];
          gap     = 4;
        end
      end
    end
  end

  // Outcome of a command given the device's replies in order: bytes the host
  // must transmit, bytes that reach the scan-code path, final error code.
  function automatic int model(input logic [7:0] op, input bit has, input logic [7:0] arg,
                               input logic [8:0] script[$], input bit txf);
    bit         in_arg = 1'b0;
    bit         in_bat = 1'b0;
    int         retries = 0;
    logic [7:0] b;
    exp_tx.push_back(op);
    if (txf) return 2;
    foreach (script[i]) begin
      b = script[i][7:0];
      if (in_bat) begin
        if (b == 8'hAA) return 0;
        if (b == 8'hFC) return 3;
        exp_fwd.push_back(b);
      end else if (b == 8'hFA) begin
        if (!in_arg && has) begin
          in_arg  = 1'b1;
          retries = 0;
          exp_tx.push_back(arg);
        end else if (op == 8'hFF) in_bat = 1'b1;
        else return 0;
      end else if (b == 8'hFE) begin
        if (retries == MAX_RETRY) return 1;
        retries++;
        exp_tx.push_back(in_arg ? arg : op);
      end else if (b == 8'hFC) begin
        return 3;
      end else begin
        exp_fwd.push_back(b);
      end
    end
    return 2;
  endfunction

  // Compare process.
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   last_code = 0;
  int   n_oreq = 0;
  int   n_key = 0;
  bit   pend_err = 1'b0;
  logic pend_val = 1'b0;

  initial begin
    int e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (oreq) begin
          n_oreq++;
          if (exp_tx.size() == 0) check("oreq_unexpected", {31'd0, oreq}, 32'd0);
          else check("obyte", {24'd0, obyte}, {24'd0, exp_tx.pop_front()});
        end
        if (key_strobe) begin
          n_key++;
          if (exp_fwd.size() == 0) check("key_unexpected", {31'd0, key_strobe}, 32'd0);
          else check("key_byte", {24'd0, key_byte}, {24'd0, exp_fwd.pop_front()});
        end
        if (pend_err) begin
          check("err_after_done", {31'd0, err}, {31'd0, pend_val});
          pend_err = 1'b0;
        end
        if (done) begin
          done_cnt++;
          done_cyc  = cyc;
          last_code = int'(err_code);
          check("busy_at_done", {31'd0, busy}, 32'd0);
          if (exp_code.size() == 0) check("done_unexpected", {31'd0, done}, 32'd0);
          else begin
            e = exp_code.pop_front();
            check("err_code", {30'd0, err_code}, e);
            pend_err = 1'b1;
            pend_val = (e != 0);
          end
        end
      end
    end
  end

  int acc_cyc = 0;

  task automatic start_cmd(input logic [7:0] op, input bit has, input logic [7:0] arg,
                           input logic [8:0] script[$], input bit txf);
    exp_code.push_back(model(op, has, arg, script, txf));
    tx_fail = txf;
    resp_q  = script;
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_byte    = op;
    cmd_has_arg = has;
    cmd_arg     = arg;
    @(negedge clk);
    cmd_valid = 1'b0;
    acc_cyc   = cyc;
  endtask

  task automatic wait_done(output int code);
    int start = done_cnt;
    for (int i = 0; i < 3000 && done_cnt == start; i++) @(negedge clk);
    check("done_seen", done_cnt - start, 1);
    code = last_code;
    repeat (3) @(negedge clk);
    check("tx_left", exp_tx.size(), 0);
    check("fwd_left", exp_fwd.size(), 0);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_cmd_ready"},  {31'd0, cmd_ready},  32'd1);
    check({tag, "_busy"},       {31'd0, busy},       32'd0);
    check({tag, "_done"},       {31'd0, done},       32'd0);
    check({tag, "_err"},        {31'd0, err},        32'd0);
    check({tag, "_err_code"},   {30'd0, err_code},   32'd0);
    check({tag, "_oreq"},       {31'd0, oreq},       32'd0);
    check({tag, "_obyte"},      {24'd0, obyte},      32'd0);
    check({tag, "_key_strobe"}, {31'd0, key_strobe}, 32'd0);
    check({tag, "_key_byte"},   {24'd0, key_byte},   32'd0);
  endtask

  initial begin
    logic [8:0] s[$];
    int code;
    int o0;
    int k0;
    int t0;

    repeat (3) @(negedge clk);
    reset_checks("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Idle forwarding.
    exp_fwd.push_back(8'h5A);
    resp_q.push_back(9'h05A);
    repeat (10) @(negedge clk);
    check("idle_fwd_left", exp_fwd.size(), 0);
    check("idle_key_byte", {24'd0, key_byte}, 32'h5A);

    // ED 07, both ACKed; a stray request mid-command must be ignored.
    o0 = n_oreq;
    s = '{9'h1FA, 9'h1FA};
    start_cmd(8'hED, 1'b1, 8'h07, s, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_byte  = 8'hEE;
    @(negedge clk);
    check("ready_while_busy", {31'd0, cmd_ready}, 32'd0);
    cmd_valid = 1'b0;
    wait_done(code);
    check("ed_code", code, 0);
    check("ed_oreqs", n_oreq - o0, 2);

    // F3, two resends then ACK.
    o0 = n_oreq;
    s = '{9'h1FE, 9'h1FE, 9'h1FA};
    start_cmd(8'hF3, 1'b0, 8'h00, s, 1'b0);
    wait_done(code);
    check("f3_retry_code", code, 0);
    check("f3_retry_oreqs", n_oreq - o0, 3);

    // F3, resend four times: retries exhausted.
    o0 = n_oreq;
    s = '{9'h1FE, 9'h1FE, 9'h1FE, 9'h1FE};
    start_cmd(8'hF3, 1'b0, 8'h00, s, 1'b0);
    wait_done(code);
    check("f3_exhaust_code", code, 1);
    check("f3_exhaust_oreqs", n_oreq - o0, 4);
    check("err_sticky", {31'd0, err}, 32'd1);

    // FF: ACK, a scan byte during BAT wait, then AA.
    k0 = n_key;
    s = '{9'h1FA, 9'h01C, 9'h0AA};
    start_cmd(8'hFF, 1'b0, 8'h00, s, 1'b0);
    check("err_clear_on_accept", {31'd0, err}, 32'd0);
    wait_done(code);
    check("ff_code", code, 0);
    check("ff_fwd_count", n_key - k0, 1);
    check("ff_key_byte", {24'd0, key_byte}, 32'h1C);

    // F3: non-response byte, then device error.
    s = '{9'h133, 9'h0FC};
    start_cmd(8'hF3, 1'b0, 8'h00, s, 1'b0);
    wait_done(code);
    check("fc_code", code, 3);
    check("fc_key_byte", {24'd0, key_byte}, 32'h33);

    // ED with no reply: response timeout, counted from the oack edge.
    s = {};
    start_cmd(8'hED, 1'b0, 8'h00, s, 1'b0);
    wait_done(code);
    check("rsp_to_code", code, 2);
    check("rsp_to_latency", done_cyc - t_ack - 1, 100);

    // Transceiver line timeout: no response wait.
    o0 = n_oreq;
    start_cmd(8'hED, 1'b0, 8'h00, s, 1'b1);
    wait_done(code);
    tx_fail = 1'b0;
    check("tx_to_code", code, 2);
    check("tx_to_oreqs", n_oreq - o0, 1);
    check("tx_to_fast", {31'd0, (done_cyc - acc_cyc) < 20}, 32'd1);

    // Reset while waiting for a response.
    t0 = t_ack;
    start_cmd(8'hED, 1'b0, 8'h00, s, 1'b0);
    for (int i = 0; i < 200 && t_ack == t0; i++) @(negedge clk);
    check("oack_before_abort", {31'd0, t_ack != t0}, 32'd1);
    repeat (5) @(negedge clk);
    check("busy_before_abort", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    reset_checks("abort");
    exp_tx.delete();
    exp_fwd.delete();
    exp_code.delete();
    resp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    o0 = n_oreq;
    s = '{9'h1FA, 9'h1FA};
    start_cmd(8'hED, 1'b1, 8'h02, s, 1'b0);
    wait_done(code);
    check("post_rst_code", code, 0);
    check("post_rst_oreqs", n_oreq - o0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_cmd_seq.md
Name: ps2_cmd_seq

Overview:
Host-to-device command sequencer for the PS/2 keyboard port. It sits between the SuperIO register front end and the low-level ps2 transceiver (istrobe/ibyte/oreq/obyte/oack/timeout). It issues one- or two-byte keyboard commands (reset FF, set LEDs ED+arg, typematic F3+arg, ...), checks the ACK (FA) or RESEND (FE) reply, retries, and waits for BAT (AA) after reset. Received bytes that are not command responses are forwarded unchanged to the scan-code path.

Parameters:
MAX_RETRY, 3, RESEND replies tolerated per byte before the command fails
RSP_TIMEOUT, 500000, clk cycles to wait for each response byte (20 ms at 25 MHz)
BAT_TIMEOUT, 25000000, clk cycles to wait for AA after the FF command is ACKed

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous, active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high in IDLE; command accepted when cmd_valid&&cmd_ready
cmd_byte  in  8  command opcode
cmd_has_arg  in  1  command carries one argument byte
cmd_arg  in  8  argument byte
done  out  1  one-cycle pulse on command completion, success or failure
err  out  1  sticky; cleared on next command accept
err_code  out  2  0=none, 1=retry exhausted, 2=timeout, 3=device error FC
busy  out  1  high from accept until done
oreq  out  1  one-cycle send pulse to transceiver
obyte  out  8  byte to send; stable from oreq until oack or timeout
oack  in  1  transceiver finished sending
tx_timeout  in  1  transceiver line timeout
istrobe  in  1  transceiver byte received (one-cycle)
ibyte  in  8  received byte
key_strobe  out  1  forwarded receive strobe, registered one cycle after istrobe
key_byte  out  8  forwarded byte

Behaviour:
- Reset values: cmd_ready=1, busy=0, done=0, err=0, err_code=0, oreq=0, obyte=0, key_strobe=0, key_byte=0; FSM in IDLE; retry and timer counters 0.
- States: IDLE, SEND_CMD, WAIT_TX, WAIT_RSP, SEND_ARG, WAIT_BAT, FINISH.
- IDLE: on accept, latch cmd_byte/cmd_has_arg/cmd_arg, set phase=CMD, clear err/err_code/retry -> SEND_CMD.
- SEND_CMD/SEND_ARG: drive obyte (command or argument), pulse oreq for one cycle -> WAIT_TX.
- WAIT_TX: oack -> WAIT_RSP and load the timer with RSP_TIMEOUT; tx_timeout -> FINISH with err_code=2.
- WAIT_RSP, on istrobe:
  - FA: if phase=CMD and has_arg, set phase=ARG, clear retry -> SEND_ARG. Else if the opcode is FF -> WAIT_BAT with the timer loaded to BAT_TIMEOUT. Else -> FINISH, success.
  - FE: if retry==MAX_RETRY -> FINISH with err_code=1; else retry++ and resend the current phase byte.
  - FC -> FINISH with err_code=3.
  - Any other byte: forwarded on key_strobe/key_byte; state unchanged; the timer is not reloaded.
- WAIT_RSP timer expiry -> FINISH with err_code=2.
- WAIT_BAT: AA -> FINISH, success; FC -> err_code=3; timer expiry -> err_code=2; other bytes forwarded.
- FINISH: pulse done for one cycle; err=(err_code!=0) -> IDLE. busy drops in the same cycle done pulses.
- Forwarding in IDLE and SEND/WAIT_TX: every istrobe is forwarded.
- Forwarding in WAIT_RSP/WAIT_BAT: only bytes consumed as responses are suppressed.
- Timer: down-counter sized $clog2(BAT_TIMEOUT+1). Expiry is the cycle it reaches 0.
- Simultaneous istrobe and timer expiry: istrobe wins.
- cmd_valid outside IDLE is ignored (cmd_ready=0).
- Asserting rst_n low mid-command aborts immediately to reset values; no done pulse.

Decomposition:
- Shared package ps2_pkg: the FSM state encoding, PS/2 constants (FA, FE, FC, AA, FF, ED, F3, F0, E0, E1), and the err_code values.
- Sub-module ps2_rsp_timer: loadable down-counter with an expiry pulse, instantiated once.

Test Plan:
- Send ED, arg 07. The model ACKs both bytes with FA -> obyte sequence ED then 07; two oreq pulses; done with err=0.
- Send F3. The model replies FE twice, then FA -> three transmissions of F3; done with err=0, retry=2 seen.
- Send F3. The model replies FE four times -> 4 transmissions total, done with err=1, err_code=1.
- Send FF. The model replies FA, then 1C, then AA -> 1C appears on key_strobe; done with err=0; FA and AA are not forwarded.
- Send ED with no reply, RSP_TIMEOUT=100 in the bench -> done 100 cycles after oack with err_code=2. Then a tx_timeout case -> err_code=2 with no response wait.
- Assert rst_n low while in WAIT_RSP -> all outputs return to reset values asynchronously, and the next command proceeds normally.
